// File: rtl/me_sad_sched_pkg.sv
// Shared types and width helpers for the motion-estimation SAD path
// (sequencer, AD array and search-result collector).
package me_pkg;

  localparam int DEF_PIXELS_IN_BATCH = 16;
  localparam int DEF_BIT_DEPTH       = 8;
  localparam int DEF_EDGE_LEN        = 8;
  localparam int DEF_PSAD_BITS       = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ACCUM  = 3'd2,
    SCAN   = 3'd3,
    RESULT = 3'd4
  } state_t;

  // Index width for n entries; never zero so single-entry builds still elaborate.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Narrowest partial SAD that cannot wrap over a full row.
  function automatic int psad_min_bits(input int bit_depth, input int edge_len);
    return bit_depth + $clog2(edge_len);
  endfunction

endpackage

// File: rtl/me_sad_sched_if.sv
// Search-result handshake: best SAD and its candidate lane, valid/ready.
interface me_sad_sched_if #(
  parameter int PSAD_BITS = 11,
  parameter int IDX_W     = 4
) ();
  logic                 res_valid;
  logic                 res_ready;
  logic [PSAD_BITS-1:0] res_sad;
  logic [IDX_W-1:0]     res_idx;

  modport master (output res_valid, res_sad, res_idx, input res_ready);
  modport slave  (input res_valid, res_sad, res_idx, output res_ready);
endinterface

// File: rtl/me_sad_sched_scan.sv
// Sequential argmin over the lane SADs: one lane per step, lane 0 first.
module sad_argmin_scan
  import me_pkg::*;
#(
  parameter  int LANES     = 16,
  parameter  int PSAD_BITS = 11,
  localparam int IDX_W     = idx_bits(LANES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic                            step,
  input  logic [LANES-1:0][PSAD_BITS-1:0] sad,
  output logic [PSAD_BITS-1:0]            best_sad,
  output logic [IDX_W-1:0]                best_idx,
  output logic                            done
);

  logic [IDX_W-1:0] j;
  logic             last;
  logic             take;

  assign last = (j == IDX_W'(LANES - 1));
  // Strict compare: on equal SADs the earlier (lower) lane is kept.
  assign take = (j == '0) || (sad[j] < best_sad);
  assign done = step && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j        <= '0;
      best_sad <= '0;
      best_idx <= '0;
    end else if (load) begin
      j        <= '0;
      best_sad <= '0;
      best_idx <= '0;
    end else if (step) begin
      if (take) begin
        best_sad <= sad[j];
        best_idx <= j;
      end
      j <= last ? '0 : j + IDX_W'(1);
    end
  end

endmodule

// File: rtl/me_sad_sched.sv
// Row sequencer for the AD stage: fetch, accumulate partial SADs over the row,
// scan lanes for the minimum and present it over a valid/ready handshake.
module me_sad_sched
  import me_pkg::*;
#(
  parameter  int PIXELS_IN_BATCH = DEF_PIXELS_IN_BATCH,
  parameter  int BIT_DEPTH       = DEF_BIT_DEPTH,
  parameter  int EDGE_LEN        = DEF_EDGE_LEN,
  parameter  int PSAD_BITS       = DEF_PSAD_BITS,
  localparam int ADDR_W          = idx_bits(EDGE_LEN),
  localparam int IDX_W           = idx_bits(PIXELS_IN_BATCH)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  output logic                                      busy,
  output logic [ADDR_W-1:0]                         cur_addr,
  input  logic [BIT_DEPTH-1:0]                      cur_pixel,
  output logic [ADDR_W-1:0]                         ref_addr,
  input  logic [PIXELS_IN_BATCH-1:0][BIT_DEPTH-1:0] ref_batch,
  output logic [BIT_DEPTH-1:0]                      ad_current,
  output logic [PIXELS_IN_BATCH-1:0][BIT_DEPTH-1:0] ad_reference,
  output logic [PIXELS_IN_BATCH-1:0][PSAD_BITS-1:0] ad_psad_in,
  input  logic [PIXELS_IN_BATCH-1:0][PSAD_BITS-1:0] ad_psad_out,
  me_sad_sched_if.master                            res
);

  if (PSAD_BITS < psad_min_bits(BIT_DEPTH, EDGE_LEN)) begin : g_psad_too_narrow
    $error("me_sad_sched: PSAD_BITS too narrow for BIT_DEPTH/EDGE_LEN");
  end

  state_t              state, state_n;
  logic [ADDR_W-1:0]   k;
  logic                last_k;
  logic [ADDR_W-1:0]   addr;
  logic                scan_done;
  logic [PSAD_BITS-1:0] best_sad;
  logic [IDX_W-1:0]    best_idx;

  assign last_k = (k == ADDR_W'(EDGE_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    busy          = (state != IDLE);
    res.res_valid = (state == RESULT);
    case (state)
      IDLE:    if (start)         state_n = FETCH;
      FETCH:                      state_n = ACCUM;
      ACCUM:   if (last_k)        state_n = SCAN;
      SCAN:    if (scan_done)     state_n = RESULT;
      RESULT:  if (res.res_ready) state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
  end

  // Pixel counter: k names the pixel whose read data is on the bus this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                k <= '0;
    else if (state == FETCH)   k <= '0;
    else if (state == ACCUM)   k <= k + ADDR_W'(1);
  end

  // Addresses run one ahead of k to cover the 1-cycle memory latency.
  always_comb begin
    addr = '0;
    if (state == ACCUM) addr = last_k ? k : k + ADDR_W'(1);
  end

  assign cur_addr     = addr;
  assign ref_addr     = addr;
  assign ad_current   = (state == ACCUM) ? cur_pixel : '0;
  assign ad_reference = (state == ACCUM) ? ref_batch : '0;

  for (genvar i = 0; i < PIXELS_IN_BATCH; i++) begin : g_lane
    logic [PSAD_BITS-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              acc <= '0;
      else if (state == FETCH) acc <= '0;
      else if (state == ACCUM) acc <= ad_psad_out[i];
    end

    assign ad_psad_in[i] = acc;
  end

  sad_argmin_scan #(
    .LANES     (PIXELS_IN_BATCH),
    .PSAD_BITS (PSAD_BITS)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == FETCH),
    .step     (state == SCAN),
    .sad      (ad_psad_in),
    .best_sad (best_sad),
    .best_idx (best_idx),
    .done     (scan_done)
  );

  assign res.res_sad = best_sad;
  assign res.res_idx = best_idx;

endmodule

// File: tb/tb_me_sad_sched.sv
// Bench for me_sad_sched: pixel memories and AD stage modelled around the DUT,
// expected SAD/argmin from a direct per-row sum of absolute differences.
module tb_me_sad_sched;

  localparam int P  = 16;
  localparam int BD = 8;
  localparam int EL = 8;
  localparam int PB = 11;
  localparam int AW = 3;
  localparam int IW = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic                  busy;
  logic [AW-1:0]         cur_addr;
  logic [BD-1:0]         cur_pixel;
  logic [AW-1:0]         ref_addr;
  logic [P-1:0][BD-1:0]  ref_batch;
  logic [BD-1:0]         ad_current;
  logic [P-1:0][BD-1:0]  ad_reference;
  logic [P-1:0][PB-1:0]  ad_psad_in;
  logic [P-1:0][PB-1:0]  ad_psad_out;

  me_sad_sched_if #(.PSAD_BITS(PB), .IDX_W(IW)) res_if ();

  me_sad_sched #(
    .PIXELS_IN_BATCH (P),
    .BIT_DEPTH       (BD),
    .EDGE_LEN        (EL),
    .PSAD_BITS       (PB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .cur_addr     (cur_addr),
    .cur_pixel    (cur_pixel),
    .ref_addr     (ref_addr),
    .ref_batch    (ref_batch),
    .ad_current   (ad_current),
    .ad_reference (ad_reference),
    .ad_psad_in   (ad_psad_in),
    .ad_psad_out  (ad_psad_out),
    .res          (res_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  // Pixel memories with 1-cycle read latency.
  logic [BD-1:0] cur_mem [EL];
  logic [BD-1:0] ref_mem [EL][P];

  always @(posedge clk) begin
    cur_pixel <= cur_mem[cur_addr];
    for (int i = 0; i < P; i++) ref_batch[i] <= ref_mem[ref_addr][i];
  end

  // External AD stage: psad_out = psad_in + |cur - ref| per lane.
  always_comb begin
    ad_psad_out = '0;
    for (int i = 0; i < P; i++)
      ad_psad_out[i] = ad_psad_in[i] + PB'((ad_current > ad_reference[i]) ?
                       ad_current - ad_reference[i] : ad_reference[i] - ad_current);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int last_hs_edge;
  int last_valid_edge;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int pat);
    for (int k = 0; k < EL; k++) begin
      case (pat)
        0: cur_mem[k] = 8'd3;
        1: cur_mem[k] = 8'd25;
        2: cur_mem[k] = 8'd0;
        3: cur_mem[k] = 8'd15;
        4: cur_mem[k] = 8'($urandom_range(0, 255));
        default: cur_mem[k] = 8'($urandom_range(0, 3));
      endcase
      for (int i = 0; i < P; i++) begin
        case (pat)
          0: ref_mem[k][i] = 8'd10;
          1: ref_mem[k][i] = 8'(20 + i);
          2: ref_mem[k][i] = (i == 9) ? 8'd254 : 8'd255;
          3: ref_mem[k][i] = 8'(i);
          4: ref_mem[k][i] = 8'($urandom_range(0, 255));
          default: ref_mem[k][i] = 8'($urandom_range(0, 3));
        endcase
      end
    end
  endtask

  // Reference: row SAD per candidate, then the first candidate holding the minimum.
  task automatic model(output int best, output int idx);
    int sad [P];
    best = 32'h7fffffff;
    for (int i = 0; i < P; i++) begin
      sad[i] = 0;
      for (int k = 0; k < EL; k++) begin
        int d;
        d = int'(cur_mem[k]) - int'(ref_mem[k][i]);
        sad[i] += (d < 0) ? -d : d;
      end
      if (sad[i] < best) best = sad[i];
    end
    idx = -1;
    for (int i = P - 1; i >= 0; i--) if (sad[i] == best) idx = i;
  endtask

  task automatic run_search(input string name, input int exp_sad, input int exp_idx);
    int s_edge;
    int n;
    start = 1'b1;
    cyc();
    start = 1'b0;
    s_edge = edge_no;
    check({name, "_busy_hi"}, int'(busy), 1);
    n = 0;
    while (!res_if.res_valid && n < 200) begin
      cyc();
      n++;
    end
    last_valid_edge = edge_no;
    check({name, "_latency"}, edge_no - s_edge, 1 + EL + P);
    check({name, "_sad"}, int'(res_if.res_sad), exp_sad);
    check({name, "_idx"}, int'(res_if.res_idx), exp_idx);
    res_if.res_ready = 1'b1;
    cyc();
    res_if.res_ready = 1'b0;
    last_hs_edge = edge_no;
    check({name, "_valid_drop"}, int'(res_if.res_valid), 0);
    check({name, "_busy_drop"}, int'(busy), 0);
  endtask

  typedef struct {
    string name;
    int    pat;
    int    exp_sad;
    int    exp_idx;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int ms, mi, hs, s_edge, n;

    tbl[0] = '{"flat_tie",   0,   56,  0};
    tbl[1] = '{"v_shape",    1,    0,  5};
    tbl[2] = '{"max_range",  2, 2032,  9};
    tbl[3] = '{"last_lane",  3,    0, 15};

    rst_n = 1'b0;
    start = 1'b0;
    res_if.res_ready = 1'b0;
    fill(0);
    cyc(); cyc();
    check("rst_busy",      int'(busy), 0);
    check("rst_valid",     int'(res_if.res_valid), 0);
    check("rst_sad",       int'(res_if.res_sad), 0);
    check("rst_idx",       int'(res_if.res_idx), 0);
    check("rst_cur_addr",  int'(cur_addr), 0);
    check("rst_ref_addr",  int'(ref_addr), 0);
    check("rst_ad_cur",    int'(ad_current), 0);
    check("rst_ad_ref_nz", int'(|ad_reference), 0);
    check("rst_psad_nz",   int'(|ad_psad_in), 0);
    rst_n = 1'b1;
    cyc();

    for (int t = 0; t < 4; t++) begin
      fill(tbl[t].pat);
      run_search(tbl[t].name, tbl[t].exp_sad, tbl[t].exp_idx);
      cyc();
    end

    for (int t = 0; t < 8; t++) begin
      fill((t % 2 == 0) ? 4 : 5);
      model(ms, mi);
      run_search($sformatf("rand%0d", t), ms, mi);
    end

    // Backpressure with start pulses in ACCUM and RESULT.
    fill(0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    s_edge = edge_no;
    cyc(); cyc(); cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (!res_if.res_valid && n < 200) begin
      cyc();
      n++;
    end
    check("bp_latency", edge_no - s_edge, 1 + EL + P);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      cyc();
      check($sformatf("bp_valid_%0d", i), int'(res_if.res_valid), 1);
      check($sformatf("bp_sad_%0d", i), int'(res_if.res_sad), 56);
      check($sformatf("bp_idx_%0d", i), int'(res_if.res_idx), 0);
    end
    start = 1'b0;
    res_if.res_ready = 1'b1;
    cyc();
    res_if.res_ready = 1'b0;
    check("bp_valid_drop", int'(res_if.res_valid), 0);
    check("bp_busy_drop", int'(busy), 0);
    cyc();
    check("bp_no_restart", int'(busy), 0);

    // Reset while accumulating pixel 4, then a clean search.
    fill(1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc(); cyc(); cyc();
    check("mid_cur_addr", int'(cur_addr), 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  int'(busy), 0);
    check("mid_rst_addr",  int'(cur_addr), 0);
    check("mid_rst_psad",  int'(|ad_psad_in), 0);
    check("mid_rst_adcur", int'(ad_current), 0);
    check("mid_rst_valid", int'(res_if.res_valid), 0);
    check("mid_rst_sad",   int'(res_if.res_sad), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    run_search("post_rst", 0, 5);

    // Back-to-back: second start the cycle after the first handshake.
    fill(4);
    model(ms, mi);
    run_search("b2b_a", ms, mi);
    hs = last_hs_edge;
    fill(2);
    run_search("b2b_b", 2032, 9);
    check("b2b_gap", last_valid_edge - hs, 2 + EL + P);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
